// File: rtl/intc_pkg.sv
// Shared types and register map for the interrupt controller.
// Rotating priority is enabled by defining INTC_ROTATE_PRIORITY_EN.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_e;

  localparam logic [1:0] INTC_MASK = 2'd0;
  localparam logic [1:0] INTC_PEND = 2'd1;
  localparam logic [1:0] INTC_STAT = 2'd2;

  localparam int INTC_STAT_ID_LSB    = 0;
  localparam int INTC_STAT_STATE_LSB = 8;

  // Packs the STATUS register image from state and current id.
  function automatic logic [31:0] intc_status(input logic [1:0] st, input logic [31:0] id);
    return ({30'd0, st} << INTC_STAT_STATE_LSB) | (id << INTC_STAT_ID_LSB);
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Find-first-set over NUM_SRC request bits, searching upward from a start
// index with wrap-around. A start of zero gives plain lowest-index priority.
module intc_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    start,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan from farthest to nearest offset so the nearest set bit is written last.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      valid = valid | req[(int'(start) + k) % NUM_SRC];
      id    = req[(int'(start) + k) % NUM_SRC] ? ID_W'((int'(start) + k) % NUM_SRC) : id;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-detected pending latch, mask, winner selection and
// irq/ack/eoi sequencing. Define INTC_ROTATE_PRIORITY_EN for round-robin priority.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               reg_write,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               eoi
);

  intc_state_e        state_r;
  logic [NUM_SRC-1:0] mask_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] src_q_r;
  logic               irq_r;
  logic [ID_W-1:0]    irq_id_r;

  logic [NUM_SRC-1:0] event_s;
  logic [NUM_SRC-1:0] w1c_s;
  logic [NUM_SRC-1:0] ack_clr_s;
  logic [NUM_SRC-1:0] eligible_s;
  logic               ack_s;
  logic [ID_W-1:0]    start_s;
  logic               win_valid_s;
  logic [ID_W-1:0]    win_id_s;
  logic               unused_wdata_s;

  assign ack_s      = (state_r == REQ) & irq_ack;
  assign event_s    = src & ~src_q_r;
  assign w1c_s      = (reg_write && (reg_addr == INTC_PEND)) ? reg_wdata[NUM_SRC-1:0] : '0;
  assign ack_clr_s  = ack_s ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << irq_id_r) : '0;
  assign eligible_s = pending_r & mask_r;
  assign unused_wdata_s = &{1'b0, reg_wdata};

`ifdef INTC_ROTATE_PRIORITY_EN
  logic [ID_W-1:0] ptr_r;

  assign start_s = ptr_r;

  // Round-robin pointer moves just past the source the CPU accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r <= '0;
    end else if (ack_s) begin
      ptr_r <= (irq_id_r == ID_W'(NUM_SRC - 1)) ? '0 : irq_id_r + {{(ID_W-1){1'b0}}, 1'b1};
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  assign start_s = '0;
`endif

  intc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req   (eligible_s),
    .start (start_s),
    .valid (win_valid_s),
    .id    (win_id_s)
  );

  // Edge detect, pending latch (a new event beats any clear) and mask register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src_q_r   <= '0;
      pending_r <= '0;
      mask_r    <= '0;
    end else begin
      src_q_r   <= src;
      pending_r <= event_s | (pending_r & ~w1c_s & ~ack_clr_s);
      if (reg_write && (reg_addr == INTC_MASK)) begin
        mask_r <= reg_wdata[NUM_SRC-1:0];
      end
    end
  end

  // Request/service sequencing with registered irq and irq_id.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      irq_r    <= 1'b0;
      irq_id_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_valid_s) begin
            irq_r    <= 1'b1;
            irq_id_r <= win_id_s;
            state_r  <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            irq_r   <= 1'b0;
            state_r <= SERVICE;
          end else if (!eligible_s[irq_id_r]) begin
            irq_r   <= 1'b0;
            state_r <= IDLE;
          end
        end
        SERVICE: begin
          irq_r <= 1'b0;
          if (eoi) begin
            state_r <= IDLE;
          end
        end
        default: begin
          irq_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Register read mux.
  always_comb begin
    reg_rdata = 32'd0;
    case (reg_addr)
      INTC_MASK: reg_rdata = 32'(mask_r);
      INTC_PEND: reg_rdata = 32'(pending_r);
      INTC_STAT: reg_rdata = intc_status(state_r, 32'(irq_id_r));
      default:   reg_rdata = 32'd0;
    endcase
  end

  assign irq    = irq_r;
  assign irq_id = irq_id_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized scoreboard bench for interrupt_controller with a behavioural model.
// Honours INTC_ROTATE_PRIORITY_EN in the model when defined.
module tb_interrupt_controller;

  localparam int N  = 8;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  src = '0;
  logic          reg_write = 1'b0;
  logic [1:0]    reg_addr = 2'd0;
  logic [31:0]   reg_wdata = 32'd0;
  logic [31:0]   reg_rdata;
  logic          irq;
  logic [IW-1:0] irq_id;
  logic          irq_ack = 1'b0;
  logic          eoi = 1'b0;

  always #5 clock = ~clock;

  interrupt_controller #(.NUM_SRC(N), .ID_W(IW)) dut (
    .clock     (clock),
    .reset     (reset),
    .src       (src),
    .reg_write (reg_write),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .eoi       (eoi)
  );

  typedef struct {
    logic        irq;
    logic [31:0] id;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int cycle_n = 0;

  // Reference model: 0 idle, 1 requesting, 2 in service.
  int           m_state = 0;
  int           m_id = 0;
  int           m_ptr = 0;
  bit           m_irq = 1'b0;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_mask = '0;
  logic [N-1:0] m_srcq = '0;

  function automatic int winner(input logic [N-1:0] el, input int start);
    for (int k = 0; k < N; k++) begin
      if (el[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_step(input logic [N-1:0] s, input bit wr, input logic [1:0] a,
                            input logic [31:0] wd, input bit ak, input bit e, input bit rn);
    logic [N-1:0] elig;
    logic [N-1:0] np;
    int w;
    if (!rn) begin
      m_state = 0; m_id = 0; m_ptr = 0; m_irq = 1'b0;
      m_pend = '0; m_mask = '0; m_srcq = '0;
    end else begin
      elig = m_pend & m_mask;
      for (int i = 0; i < N; i++) begin
        bit ev;
        bit clr;
        ev    = s[i] && !m_srcq[i];
        clr   = (wr && a == 2'd1 && wd[i]) || (m_state == 1 && ak && m_id == i);
        np[i] = ev || (m_pend[i] && !clr);
      end
      case (m_state)
        0: begin
`ifdef INTC_ROTATE_PRIORITY_EN
          w = winner(elig, m_ptr);
`else
          w = winner(elig, 0);
`endif
          if (w >= 0) begin
            m_irq = 1'b1; m_id = w; m_state = 1;
          end
        end
        1: begin
          if (ak) begin
            m_irq = 1'b0; m_state = 2;
`ifdef INTC_ROTATE_PRIORITY_EN
            m_ptr = (m_id + 1) % N;
`endif
          end else if (!elig[m_id]) begin
            m_irq = 1'b0; m_state = 0;
          end
        end
        default: begin
          if (e) m_state = 0;
        end
      endcase
      m_pend = np;
      if (wr && a == 2'd0) m_mask = wd[N-1:0];
      m_srcq = s;
    end
  endtask

  // Drive one cycle of stimulus and queue the expected post-edge outputs.
  task automatic tick(input logic [N-1:0] s = '0, input bit wr = 1'b0, input logic [1:0] a = 2'd0,
                      input logic [31:0] wd = 32'd0, input bit ak = 1'b0, input bit e = 1'b0,
                      input bit rn = 1'b1);
    exp_t x;
    @(negedge clock);
    src = s; reg_write = wr; reg_addr = a; reg_wdata = wd; irq_ack = ak; eoi = e; reset = rn;
    model_step(s, wr, a, wd, ak, e, rn);
    cycle_n++;
    x.irq = m_irq;
    x.id  = 32'(m_id);
    case (a)
      2'd0:    x.rdata = 32'(m_mask);
      2'd1:    x.rdata = 32'(m_pend);
      2'd2:    x.rdata = (32'(m_state) << 8) | 32'(m_id);
      default: x.rdata = 32'd0;
    endcase
    x.cyc = cycle_n;
    sb_q.push_back(x);
  endtask

  // Monitor: compare DUT outputs just after each active edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("irq", e.cyc, 32'(irq), 32'(e.irq));
        check("irq_id", e.cyc, 32'(irq_id), e.id);
        check("reg_rdata", e.cyc, reg_rdata, e.rdata);
      end
    end
  end

  initial begin : stim
    bit ak;
    bit ev;
    tick(.rn(1'b0), .a(2'd2));
    tick(.rn(1'b0));
    // 1: single timer pulse, ack clears pending
    tick(.wr(1'b1), .a(2'd0), .wd(32'h01));
    tick(.s(8'h01));
    tick(.a(2'd1));
    tick(.a(2'd2));
    tick(.a(2'd1), .ak(1'b1));
    tick(.a(2'd1));
    tick(.e(1'b1), .a(2'd2));
    // 2: masked pending, then unmask
    tick(.wr(1'b1), .a(2'd0), .wd(32'h00));
    tick(.s(8'h08));
    tick(.a(2'd1));
    tick(.a(2'd2));
    tick(.wr(1'b1), .a(2'd0), .wd(32'h08));
    tick(.a(2'd2));
    tick(.a(2'd2));
    tick(.ak(1'b1));
    tick(.e(1'b1));
    // 3: two sources together; id 2 re-pends during service
    tick(.wr(1'b1), .a(2'd0), .wd(32'hFF));
    tick(.s(8'h24));
    tick(.a(2'd2));
    tick(.a(2'd2), .ak(1'b1));
    tick(.s(8'h04), .a(2'd1));
    tick(.e(1'b1), .a(2'd1));
    tick(.a(2'd2));
    tick(.a(2'd2), .ak(1'b1));
    tick(.e(1'b1));
    tick(.a(2'd2));
    tick(.a(2'd2), .ak(1'b1));
    tick(.e(1'b1));
    tick(.a(2'd1));
    // 4: W1C withdraws a request
    tick(.wr(1'b1), .a(2'd1), .wd(32'hFF));
    tick(.s(8'h10));
    tick(.a(2'd2));
    tick(.wr(1'b1), .a(2'd1), .wd(32'h10));
    tick(.a(2'd2));
    tick(.a(2'd2));
    // 5: ack coincides with a new event on the same source
    tick(.s(8'h02));
    tick(.a(2'd2));
    tick(.a(2'd2));
    tick(.s(8'h02), .ak(1'b1), .a(2'd1));
    tick(.a(2'd1));
    tick(.e(1'b1), .a(2'd2));
    tick(.a(2'd2));
    tick(.ak(1'b1));
    tick(.e(1'b1));
    // 6: reset during service with pending bits
    tick(.wr(1'b1), .a(2'd1), .wd(32'hFF));
    tick(.s(8'h06));
    tick(.a(2'd2));
    tick(.a(2'd2), .ak(1'b1));
    tick(.s(8'h02), .a(2'd1));
    tick(.a(2'd1), .rn(1'b0));
    tick(.a(2'd0), .rn(1'b0));
    tick(.a(2'd2), .rn(1'b0));
    tick(.a(2'd1));
    // Randomized traffic
    tick(.wr(1'b1), .a(2'd0), .wd(32'hFF));
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] s;
      bit wr;
      logic [1:0] a;
      logic [31:0] wd;
      s  = N'($urandom & $urandom & $urandom);
      wr = ($urandom_range(0, 9) == 0);
      a  = 2'($urandom_range(0, 3));
      wd = (a == 2'd0) ? ($urandom | 32'h1) : $urandom;
      ak = (m_state == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      ev = (m_state == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      tick(.s(s), .wr(wr), .a(a), .wd(wd), .ak(ak), .e(ev), .rn($urandom_range(0, 499) != 0));
    end
    tick(.a(2'd2));
    @(posedge clock);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
